// File: rtl/univ_reg_pkg.sv
// Purpose : shared mode encoding for the universal register.
// Latency : n/a (types and constants only).
// Backpressure: n/a.
package univ_reg_pkg;

    localparam int MODE_W = 3;

    // Per-cycle operation select; values are fixed because they are driven
    // straight from the 3-bit mode port.
    typedef enum logic [MODE_W-1:0] {
        MODE_HOLD = 3'd0,
        MODE_LOAD = 3'd1,
        MODE_SHL  = 3'd2,
        MODE_SHR  = 3'd3,
        MODE_ROL  = 3'd4,
        MODE_ROR  = 3'd5,
        MODE_INC  = 3'd6,
        MODE_DEC  = 3'd7
    } mode_e;

endpackage

// File: rtl/univ_reg_next.sv
// Purpose : combinational next-state and next-carry for univ_reg.
// Latency : zero, pure combinational.
// Backpressure: none; the caller decides whether to commit the result.
//
// Ports: q (current state), mode, d, sin_msb, sin_lsb in;
//        q_next, carry_next out. carry_next is the shift-out / wrap flag
//        the top register stores when UNIV_REG_CARRY_EN is defined.
module univ_reg_next
    import univ_reg_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] q,
    input  logic [2:0]       mode,
    input  logic [WIDTH-1:0] d,
    input  logic             sin_msb,
    input  logic             sin_lsb,
    output logic [WIDTH-1:0] q_next,
    output logic             carry_next
);

    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    always_comb begin
        q_next     = q;
        carry_next = 1'b0;
        case (mode)
            MODE_HOLD: begin
                q_next     = q;
                carry_next = 1'b0;
            end
            MODE_LOAD: begin
                // Only path through which d reaches the state.
                q_next     = d;
                carry_next = 1'b0;
            end
            MODE_SHL: begin
                q_next     = {q[WIDTH-2:0], sin_lsb};
                carry_next = q[WIDTH-1];
            end
            MODE_SHR: begin
                q_next     = {sin_msb, q[WIDTH-1:1]};
                carry_next = q[0];
            end
            MODE_ROL: begin
                q_next     = {q[WIDTH-2:0], q[WIDTH-1]};
                carry_next = q[WIDTH-1];
            end
            MODE_ROR: begin
                q_next     = {q[0], q[WIDTH-1:1]};
                carry_next = q[0];
            end
            MODE_INC: begin
                // Wraps modulo 2^WIDTH; carry marks the all-ones -> 0 step.
                q_next     = q + ONE;
                carry_next = &q;
            end
            MODE_DEC: begin
                // Wraps modulo 2^WIDTH; borrow marks the 0 -> all-ones step.
                q_next     = q - ONE;
                carry_next = ~|q;
            end
            default: begin
                q_next     = q;
                carry_next = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/univ_reg.sv
// Purpose : WIDTH-bit universal register (hold/load/shift/rotate/inc/dec).
// Latency : q updates one clk after the sampling edge; sout_*/zero follow q.
// Backpressure: none; en=0 freezes q and carry.
//
// Ports: clk, rst (sync, active-high), en, mode[2:0], d, sin_msb, sin_lsb in;
//        q, sout_msb, sout_lsb, zero, carry out.
// Build option: define UNIV_REG_CARRY_EN to get a registered carry /
//        borrow / shift-out flag; otherwise carry is a constant 0 and no
//        flop exists for it, but the port stays so instances are identical.
module univ_reg
    import univ_reg_pkg::*;
#(
    parameter int          WIDTH       = 8,
    parameter logic [63:0] RESET_VALUE = 64'h0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [2:0]       mode,
    input  logic [WIDTH-1:0] d,
    input  logic             sin_msb,
    input  logic             sin_lsb,
    output logic [WIDTH-1:0] q,
    output logic             sout_msb,
    output logic             sout_lsb,
    output logic             zero,
    output logic             carry
);

    // Wider reset values are truncated to the register width.
    localparam logic [WIDTH-1:0] RST_Q = RESET_VALUE[WIDTH-1:0];

    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] q_d;
    logic [WIDTH-1:0] q_next;
    logic             carry_next;

    univ_reg_next #(
        .WIDTH (WIDTH)
    ) u_next (
        .q          (q_q),
        .mode       (mode),
        .d          (d),
        .sin_msb    (sin_msb),
        .sin_lsb    (sin_lsb),
        .q_next     (q_next),
        .carry_next (carry_next)
    );

    // en=0 holds; rst overrides both inside the flop process.
    always_comb begin
        q_d = q_q;
        if (en) begin
            q_d = q_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            q_q <= RST_Q;
        end else begin
            q_q <= q_d;
        end
    end

`ifdef UNIV_REG_CARRY_EN
    logic carry_q;
    logic carry_d;

    always_comb begin
        carry_d = carry_q;
        if (en) begin
            carry_d = carry_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            carry_q <= 1'b0;
        end else begin
            carry_q <= carry_d;
        end
    end

    assign carry = carry_q;
`else
    logic unused_carry_next;
    assign unused_carry_next = carry_next;
    assign carry             = 1'b0;
`endif

    assign q        = q_q;
    assign sout_msb = q_q[WIDTH-1];
    assign sout_lsb = q_q[0];
    assign zero     = (q_q == '0);

`ifndef SYNTHESIS
    always_ff @(posedge clk) begin
        assert (WIDTH >= 2) else $error("univ_reg: WIDTH must be at least 2");
    end
`endif

endmodule

// File: tb/tb_univ_reg.sv
// Purpose : self-checking bench for univ_reg (WIDTH=8), scoreboard style.
// Latency : expectations are tagged with the cycle they become visible.
// Backpressure: n/a.
module tb_univ_reg;
    import univ_reg_pkg::*;

`ifdef UNIV_REG_CARRY_EN
    localparam bit CARRY_ON = 1'b1;
`else
    localparam bit CARRY_ON = 1'b0;
`endif

    logic       clk;
    logic       rst_a;
    logic       rst_b;
    logic       en;
    logic [2:0] mode;
    logic [7:0] d;
    logic       sin_msb;
    logic       sin_lsb;

    logic [7:0] q_a, q_b;
    logic       smsb_a, smsb_b, slsb_a, slsb_b, zero_a, zero_b, carry_a, carry_b;

    univ_reg #(.WIDTH(8), .RESET_VALUE(64'h00)) u_dut_a (
        .clk(clk), .rst(rst_a), .en(en), .mode(mode), .d(d),
        .sin_msb(sin_msb), .sin_lsb(sin_lsb),
        .q(q_a), .sout_msb(smsb_a), .sout_lsb(slsb_a), .zero(zero_a), .carry(carry_a)
    );

    univ_reg #(.WIDTH(8), .RESET_VALUE(64'h5A)) u_dut_b (
        .clk(clk), .rst(rst_b), .en(en), .mode(mode), .d(d),
        .sin_msb(sin_msb), .sin_lsb(sin_lsb),
        .q(q_b), .sout_msb(smsb_b), .sout_lsb(slsb_b), .zero(zero_b), .carry(carry_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         tag;
        bit         sel_b;
        string      name;
        logic [7:0] q;
        logic       c;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h required %h", name, act, req);
        end
    endtask

    // Monitor: compares every expectation due at this cycle.
    always @(negedge clk) begin
        exp_t e;
        while (sb.size() > 0 && sb[0].tag <= cyc) begin
            e = sb.pop_front();
            if (e.tag < cyc) begin
                total++;
                bad++;
                $display("FAIL %s: expectation stale at cycle %0d required cycle %0d", e.name, cyc, e.tag);
            end else if (!e.sel_b) begin
                check({e.name, ".q"},     q_a,           e.q);
                check({e.name, ".carry"}, {7'd0, carry_a}, {7'd0, e.c});
                check({e.name, ".zero"},  {7'd0, zero_a},  {7'd0, (e.q == 8'h00)});
                check({e.name, ".smsb"},  {7'd0, smsb_a},  {7'd0, e.q[7]});
                check({e.name, ".slsb"},  {7'd0, slsb_a},  {7'd0, e.q[0]});
            end else begin
                check({e.name, ".q"},     q_b,           e.q);
                check({e.name, ".carry"}, {7'd0, carry_b}, {7'd0, e.c});
                check({e.name, ".zero"},  {7'd0, zero_b},  {7'd0, (e.q == 8'h00)});
                check({e.name, ".smsb"},  {7'd0, smsb_b},  {7'd0, e.q[7]});
                check({e.name, ".slsb"},  {7'd0, slsb_b},  {7'd0, e.q[0]});
            end
        end
    end

    // Drive one cycle of inputs; the hand-computed result is expected after
    // the next rising edge. c_on is the carry when the carry flop is built.
    task automatic step(input string name, input bit sel_b, input logic r,
                        input logic e_n, input logic [2:0] m, input logic [7:0] dv,
                        input logic smsb, input logic slsb,
                        input logic [7:0] exp_q, input logic c_on);
        exp_t e;
        @(posedge clk);
        #1;
        if (sel_b) rst_b = r; else rst_a = r;
        en      = e_n;
        mode    = m;
        d       = dv;
        sin_msb = smsb;
        sin_lsb = slsb;
        e.tag   = cyc + 1;
        e.sel_b = sel_b;
        e.name  = name;
        e.q     = exp_q;
        e.c     = CARRY_ON ? c_on : 1'b0;
        sb.push_back(e);
    endtask

    initial begin
        rst_a = 1'b1; rst_b = 1'b1; en = 1'b0; mode = MODE_HOLD;
        d = 8'h00; sin_msb = 1'b0; sin_lsb = 1'b0;

        // reset wins over an enabled load
        step("rst0", 0, 1, 1, MODE_LOAD, 8'hAA, 0, 0, 8'h00, 0);
        step("rst1", 0, 1, 1, MODE_LOAD, 8'hAA, 0, 0, 8'h00, 0);
        // load then shift left with a 1 entering at bit 0
        step("ld81", 0, 0, 1, MODE_LOAD, 8'h81, 0, 0, 8'h81, 0);
        step("shl",  0, 0, 1, MODE_SHL,  8'h00, 0, 1, 8'h03, 1);
        // rotate right twice
        step("ld81b", 0, 0, 1, MODE_LOAD, 8'h81, 0, 0, 8'h81, 0);
        step("ror1",  0, 0, 1, MODE_ROR,  8'h00, 0, 0, 8'hC0, 1);
        step("ror2",  0, 0, 1, MODE_ROR,  8'h00, 0, 0, 8'h60, 0);
        // increment through the all-ones wrap
        step("ldFE", 0, 0, 1, MODE_LOAD, 8'hFE, 0, 0, 8'hFE, 0);
        step("inc1", 0, 0, 1, MODE_INC,  8'h00, 0, 0, 8'hFF, 0);
        step("inc2", 0, 0, 1, MODE_INC,  8'h00, 0, 0, 8'h00, 1);
        // decrement through zero, then en=0 freezes q and carry
        step("dec0", 0, 0, 1, MODE_DEC,  8'h00, 0, 0, 8'hFF, 1);
        for (int i = 0; i < 3; i++) begin
            step("hold_en0", 0, 0, 0, MODE_INC, 8'h12, 1, 1, 8'hFF, 1);
        end
        // en=0 with load and undefined data: nothing leaks
        step("hold_x", 0, 0, 0, MODE_LOAD, 8'hxx, 0, 0, 8'hFF, 1);
        // shift right with 1 entering the msb, rotate left, dec to zero
        step("ld01",  0, 0, 1, MODE_LOAD, 8'h01, 0, 0, 8'h01, 0);
        step("shr",   0, 0, 1, MODE_SHR,  8'hxx, 1, 0, 8'h80, 1);
        step("rol",   0, 0, 1, MODE_ROL,  8'hxx, 0, 0, 8'h01, 1);
        step("shl0",  0, 0, 1, MODE_SHL,  8'hxx, 1, 0, 8'h02, 0);
        step("dec2",  0, 0, 1, MODE_DEC,  8'hxx, 0, 0, 8'h01, 0);
        step("dec1",  0, 0, 1, MODE_DEC,  8'hxx, 0, 0, 8'h00, 0);
        step("holdm", 0, 0, 1, MODE_HOLD, 8'hxx, 0, 0, 8'h00, 0);
        step("ldA5",  0, 0, 1, MODE_LOAD, 8'hA5, 0, 0, 8'hA5, 0);

        // RESET_VALUE=5A: counting abandoned by a mid-sequence reset
        step("b_rst",  1, 1, 1, MODE_INC, 8'h00, 0, 0, 8'h5A, 0);
        step("b_inc1", 1, 0, 1, MODE_INC, 8'h00, 0, 0, 8'h5B, 0);
        step("b_rst2", 1, 1, 1, MODE_INC, 8'h00, 0, 0, 8'h5A, 0);
        step("b_inc3", 1, 0, 1, MODE_INC, 8'h00, 0, 0, 8'h5B, 0);

        // drain the scoreboard with a bounded wait
        for (int i = 0; i < 10 && sb.size() > 0; i++) begin
            @(posedge clk);
        end
        if (sb.size() > 0) begin
            total++;
            bad++;
            $display("FAIL drain: %0d expectations left, required 0", sb.size());
        end
        @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/univ_reg.md
Name: univ_reg

Overview:
- Parametrised universal register; the multi-bit, multi-mode successor to the team's single-bit flip_flop storage element.
- One WIDTH-bit state register, updated on the rising edge of clk.
- Per-cycle operation chosen by mode: hold, parallel load, shift left/right, rotate left/right, increment, decrement.
- Used as a general datapath register, shifter or counter.

Parameters:
- WIDTH, 8: register width in bits; legal range 2..64.
- RESET_VALUE, 0: value loaded into q on reset; WIDTH bits, truncated if wider.

Ports:
- clk  input  1  clock; all state changes on its rising edge.
- rst  input  1  synchronous, active-high reset.
- en  input  1  operation enable; 0 forces hold regardless of mode.
- mode  input  3  operation select (encoding in Behaviour).
- d  input  WIDTH  parallel load data.
- sin_msb  input  1  serial input entering at bit WIDTH-1 on shift right.
- sin_lsb  input  1  serial input entering at bit 0 on shift left.
- q  output  WIDTH  register contents.
- sout_msb  output  1  equals q[WIDTH-1], combinational from q.
- sout_lsb  output  1  equals q[0], combinational from q.
- zero  output  1  1 when q == 0, combinational from q.
- carry  output  1  registered carry/borrow/shift-out flag (see Optional Feature).

Behaviour:
- Clock and reset: one clock (clk); rst is synchronous and active-high. No asynchronous paths.
- Priority each rising clk edge: rst > en=0 > mode.
- rst=1: q <= RESET_VALUE, carry <= 0. Ignores en, mode, d.
- en=0: q and carry hold.
- Mode encoding, applied when en=1:
  - 0 HOLD: q holds.
  - 1 LOAD: q <= d.
  - 2 SHL: q <= {q[WIDTH-2:0], sin_lsb}.
  - 3 SHR: q <= {sin_msb, q[WIDTH-1:1]}.
  - 4 ROL: q <= {q[WIDTH-2:0], q[WIDTH-1]}.
  - 5 ROR: q <= {q[0], q[WIDTH-1:1]}.
  - 6 INC: q <= q + 1, modulo 2^WIDTH.
  - 7 DEC: q <= q - 1, modulo 2^WIDTH.
- Latency: q reflects the operation one cycle after the sampling edge. sout_msb, sout_lsb and zero follow q with no added cycle.
- Wrap-around: INC at all-ones gives 0; DEC at 0 gives all-ones. No saturation.
- Reset mid-operation: a counting or shifting sequence is abandoned. q = RESET_VALUE the cycle after rst, and the operation resumes from RESET_VALUE once rst drops.
- No X propagation from d unless mode==LOAD with en=1.
- Sim-time assertion fires if WIDTH < 2.

Optional Feature:
- Macro: UNIV_REG_CARRY_EN.
- Defined: carry is updated on every en=1, rst=0 edge:
  - INC: 1 iff q was all-ones.
  - DEC: 1 iff q was 0.
  - SHL, ROL: old q[WIDTH-1].
  - SHR, ROR: old q[0].
  - HOLD, LOAD: 0.
- Not defined: carry is tied to constant 0, with no flop inferred. The port stays present so instantiations are identical.

Decomposition:
- Package univ_reg_pkg holds the 3-bit mode type and the named constants MODE_HOLD .. MODE_DEC (values 0..7).
- One sub-module, univ_reg_next: purely combinational next-state and next-carry logic (inputs q, mode, d, sin_msb, sin_lsb; outputs q_next, carry_next).
- Top level holds only the flops, the rst/en priority and the output assigns.

Test Plan (WIDTH=8, RESET_VALUE=8'h00 unless noted):
1. rst=1 for 2 cycles, with en=1, mode=LOAD, d=8'hAA -> q=8'h00, carry=0, zero=1. Reset wins over load.
2. LOAD 8'h81, then SHL with sin_lsb=1 -> q=8'h03, sout_msb=0. With UNIV_REG_CARRY_EN: carry=1.
3. LOAD 8'h81, then ROR twice -> q=8'hC0 then 8'h60.
4. LOAD 8'hFE, then INC 2 cycles -> q=8'hFF then 8'h00, zero=1. With macro: carry=0 then 1.
5. q=8'h00, DEC -> q=8'hFF. Then en=0 with mode=INC for 3 cycles -> q stays 8'hFF.
6. RESET_VALUE=8'h5A: INC for 3 cycles, rst on the 2nd cycle -> q=8'h5B, 8'h5A, 8'h5B. Without macro, carry stays 0 throughout.
